// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES datapath constants, GF(2^8) xtime and byte-index
//               helpers for the 128-bit column-major state.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int         NR_DEFAULT = 10;
  localparam int         ROUND_W    = 4;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Column-major byte numbering: byte index = row + 4*col.
  function automatic int byte_idx(input int row, input int col);
    return row + 4 * col;
  endfunction

  // Byte 0 sits in the most significant position of the 128-bit state.
  function automatic int byte_msb(input int idx);
    return 127 - 8 * idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_column.sv
`default_nettype none
// ============================================================================
// Module      : mix_column
// Description : Combinational AES MixColumns on one 32-bit column (row 0 = MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign {w_a0, w_a1, w_a2, w_a3} = col_in;

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3*x is folded in as xtime(x) ^ x.
  assign col_out[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign col_out[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign col_out[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign col_out[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule
`default_nettype wire

// File: rtl/shift_mix_r.sv
`default_nettype none
// ============================================================================
// Module      : shift_mix_r
// Description : Two-stage valid/ready AES ShiftRows (stage A) + MixColumns
//               (stage B, bypassed in the final round) with round tag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_mix_r
  import aes_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [127:0]        in_state,
  input  logic [ROUND_W-1:0]  in_round,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [127:0]        out_state,
  output logic [ROUND_W-1:0]  out_round,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_err
);

  localparam logic [ROUND_W-1:0] c_nr = ROUND_W'(NR);

  logic [127:0]       r_a_state;
  logic [ROUND_W-1:0] r_a_round;
  logic               r_a_valid;
  logic [127:0]       r_b_state;
  logic [ROUND_W-1:0] r_b_round;
  logic               r_b_err;
  logic               r_b_valid;

  logic               w_b_free;
  logic               w_a_free;
  logic [127:0]       w_shifted;
  logic [127:0]       w_mixed;
  logic [127:0]       w_b_next;
  logic               w_a_err;

  assign w_b_free = !r_b_valid || out_ready;
  assign w_a_free = !r_a_valid || w_b_free;
  assign in_ready = w_a_free;

  // Row r rotates left by r columns: out byte r+4c <- in byte r+4((c+r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      localparam int c_dst = byte_msb(byte_idx(r, c));
      localparam int c_src = byte_msb(byte_idx(r, (c + r) % 4));
      assign w_shifted[c_dst -: 8] = in_state[c_src -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_column u_mix_column (
      .col_in  (r_a_state[127-32*c -: 32]),
      .col_out (w_mixed[127-32*c -: 32])
    );
  end

  assign w_b_next = (r_a_round == c_nr) ? r_a_state : w_mixed;
  assign w_a_err  = (r_a_round == '0) || (r_a_round > c_nr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_state <= '0;
      r_a_round <= '0;
      r_a_valid <= 1'b0;
      r_b_state <= '0;
      r_b_round <= '0;
      r_b_err   <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      // A empties whenever it is free: its content either moves to B or it was empty.
      if (w_a_free) begin
        r_a_valid <= in_valid;
        if (in_valid) begin
          r_a_state <= w_shifted;
          r_a_round <= in_round;
        end
      end
      if (w_b_free) begin
        r_b_valid <= r_a_valid;
        if (r_a_valid) begin
          r_b_state <= w_b_next;
          r_b_round <= r_a_round;
          r_b_err   <= w_a_err;
        end
      end
    end
  end

  assign out_state = r_b_state;
  assign out_round = r_b_round;
  assign out_valid = r_b_valid;
  assign out_err   = r_b_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_mix_r.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_mix_r
// Description : Directed self-checking bench for shift_mix_r.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_mix_r;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] c_fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] c_fips_mix = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] c_fips_sr  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] c_col_in   = {4{32'hdb135345}};
  localparam logic [127:0] c_col_out  = {4{32'h8e4da1bc}};

  shift_mix_r #(.NR(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_state  (in_state),
    .in_round  (in_round),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_round  = '0;
    out_ready = 1'b1;
    #12;
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_state !== '0)    begin bad++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    total++; if (out_round !== 4'd0)  begin bad++; $display("FAIL reset_out_round: got %0d want 0", out_round); end
    total++; if (out_err !== 1'b0)    begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single transfer with out_ready=1: out_valid must appear exactly two edges later.
  task automatic run_single(input logic [127:0] st, input logic [3:0] rnd,
                            input logic [127:0] exp_st, input logic exp_err,
                            input string name);
    @(negedge clk);
    out_ready = 1'b1;
    in_state  = st;
    in_round  = rnd;
    in_valid  = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_state !== exp_st || out_round !== rnd || out_err !== exp_err) begin
      bad++;
      $display("FAIL %s: got v=%b st=%h rnd=%0d err=%b want v=1 st=%h rnd=%0d err=%b",
               name, out_valid, out_state, out_round, out_err, exp_st, rnd, exp_err);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: got %b want 0", name, out_valid); end
  endtask

  task automatic test_single_mix();
    run_single(c_fips_in, 4'd1, c_fips_mix, 1'b0, "mix_round1");
  endtask

  task automatic test_final_round();
    run_single(c_fips_in, 4'd10, c_fips_sr, 1'b0, "final_bypass");
  endtask

  task automatic test_column();
    run_single(c_col_in, 4'd2, c_col_out, 1'b0, "column");
  endtask

  task automatic test_error_tags();
    run_single(c_fips_in, 4'd0, c_fips_mix, 1'b1, "err_round0");
    run_single(c_fips_in, 4'd11, c_fips_mix, 1'b1, "err_round11");
  endtask

  task automatic test_backpressure();
    logic [127:0] st_in  [8];
    logic [127:0] st_exp [8];
    logic [3:0]   rd_in  [8];
    logic [31:0]  rdy_pat;
    logic [127:0] hold_state;
    logic [3:0]   hold_round;
    bit           hold_valid;
    bit           in_x, out_x, exp_rdy;
    int           sent, rcvd, occ;

    st_in[0] = c_fips_in;             rd_in[0] = 4'd1;  st_exp[0] = c_fips_mix;
    st_in[1] = c_fips_in;             rd_in[1] = 4'd10; st_exp[1] = c_fips_sr;
    st_in[2] = c_col_in;              rd_in[2] = 4'd3;  st_exp[2] = c_col_out;
    st_in[3] = {4{32'hf20a225c}};     rd_in[3] = 4'd4;  st_exp[3] = {4{32'h9fdc589d}};
    st_in[4] = {4{32'h01010101}};     rd_in[4] = 4'd5;  st_exp[4] = {4{32'h01010101}};
    st_in[5] = {4{32'hc6c6c6c6}};     rd_in[5] = 4'd6;  st_exp[5] = {4{32'hc6c6c6c6}};
    st_in[6] = {4{32'hd4d4d4d5}};     rd_in[6] = 4'd7;  st_exp[6] = {4{32'hd5d5d7d6}};
    st_in[7] = {4{32'h2d26314c}};     rd_in[7] = 4'd9;  st_exp[7] = {4{32'h4d7ebdf8}};

    rdy_pat    = 32'b1011_0010_0111_0001_1100_1010_0011_1001;
    sent       = 0;
    rcvd       = 0;
    occ        = 0;
    hold_valid = 1'b0;
    hold_state = '0;
    hold_round = '0;

    for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready = rdy_pat[cyc % 32];
      if (sent < 8) begin
        in_valid = 1'b1;
        in_state = st_in[sent];
        in_round = rd_in[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL bp_in_ready cyc=%0d: got %b want %b (occupancy %0d)", cyc, in_ready, exp_rdy, occ);
      end
      if (hold_valid) begin
        total++;
        if (out_valid !== 1'b1 || out_state !== hold_state || out_round !== hold_round) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d: got v=%b st=%h rnd=%0d want v=1 st=%h rnd=%0d",
                   cyc, out_valid, out_state, out_round, hold_state, hold_round);
        end
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        total++;
        if (out_state !== st_exp[rcvd] || out_round !== rd_in[rcvd] || out_err !== 1'b0) begin
          bad++;
          $display("FAIL bp_data item=%0d: got st=%h rnd=%0d err=%b want st=%h rnd=%0d err=0",
                   rcvd, out_state, out_round, out_err, st_exp[rcvd], rd_in[rcvd]);
        end
        rcvd++;
      end
      hold_valid = out_valid && !out_ready;
      hold_state = out_state;
      hold_round = out_round;
      if (in_x) sent++;
      occ = occ + int'(in_x) - int'(out_x);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcvd != 8) begin bad++; $display("FAIL bp_count: got %0d items want 8", rcvd); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = c_fips_in;
    in_round  = 4'd1;
    @(negedge clk);
    in_state  = c_col_in;
    in_round  = 4'd2;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mrst_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_state !== '0 || in_ready !== 1'b1 || out_round !== 4'd0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL mrst_clear: got v=%b st=%h rdy=%b rnd=%0d err=%b want 0 0 1 0 0",
               out_valid, out_state, in_ready, out_round, out_err);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_single(c_col_in, 4'd2, c_col_out, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single_mix();
    test_final_round();
    test_column();
    test_error_tags();
    test_backpressure();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
